mips_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the multi-cycle MIPS datapath (mipscpu). It holds the PC and a loadable instruction memory, and resolves j/beq/bne. Each instruction is presented on instrword for a fixed number of cycles, and newinstr pulses once at the start of each instruction. Branch comparison comes back from the datapath on cmp_equal.

---
 rtl/mips_fetch_unit_if.sv | 27 ++
 rtl/mips_fetch_unit.sv | 123 ++++++++++++
 tb/tb_mips_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus: run/load/branch-compare inputs and the instruction stream outputs.
// The master drives control and load signals; the slave is the fetch unit.
interface mips_fetch_unit_if #(
    parameter int unsigned IMEM_DEPTH = 64
);
    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic          run;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          cmp_equal;
    logic [31:0]   instrword;
    logic          newinstr;
    logic [31:0]   pc;
    logic          halted;

    modport master (
        output run, load_en, load_addr, load_data, cmp_equal,
        input  instrword, newinstr, pc, halted
    );

    modport slave (
        input  run, load_en, load_addr, load_data, cmp_equal,
        output instrword, newinstr, pc, halted
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// Instruction fetch/sequencing stage for the multi-cycle MIPS datapath: holds the PC and
// a loadable instruction memory, presents each word for a fixed window, resolves j/beq/bne.
module mips_fetch_unit #(
    parameter int unsigned IMEM_DEPTH       = 64,
    parameter int unsigned CYCLES_PER_INSTR = 5,
    parameter logic [31:0] RESET_PC         = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst,
    mips_fetch_unit_if.slave bus
);
    localparam int unsigned AW = $clog2(IMEM_DEPTH);
    localparam int unsigned CW = $clog2(CYCLES_PER_INSTR);
    localparam logic [CW-1:0] LAST_CNT = CW'(CYCLES_PER_INSTR - 1);

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    state_e        r_state, w_state_nxt;
    logic [31:0]   r_pc, w_pc_nxt;
    logic [31:0]   r_instr, w_instr_nxt;
    logic          r_newinstr, w_newinstr_nxt;
    logic          r_halted, w_halted_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic [31:0]   r_imem [IMEM_DEPTH];

    logic [AW-1:0] w_idx;
    logic [31:0]   w_pc4;
    logic [31:0]   w_br_target;
    logic [5:0]    w_opcode;
    logic          w_last;
    logic          w_load_ok;

    assign w_idx       = r_pc[AW+1:2];
    assign w_pc4       = r_pc + 32'd4;
    assign w_br_target = w_pc4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_opcode    = r_instr[31:26];
    assign w_last      = (r_cnt == LAST_CNT);

    // Loads only land while the sequencer is parked, so a load never races a fetch.
    assign w_load_ok = bus.load_en && ((r_state == StIdle) || (r_state == StHalt));

    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_imem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_newinstr <= 1'b0;
            r_halted   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_newinstr <= w_newinstr_nxt;
            r_halted   <= w_halted_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_newinstr_nxt = 1'b0;
        w_halted_nxt   = r_halted;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            StIdle: begin
                if (bus.run) begin
                    w_state_nxt = StFetch;
                end
            end
            StFetch: begin
                w_instr_nxt    = r_imem[w_idx];
                w_newinstr_nxt = 1'b1;
                w_cnt_nxt      = '0;
                w_state_nxt    = StExec;
            end
            StExec: begin
                w_cnt_nxt = r_cnt + CW'(1);
                // Retire on the final window cycle; cmp_equal is only meaningful here.
                if (w_last) begin
                    w_state_nxt = bus.run ? StFetch : StIdle;
                    case (w_opcode)
                        OP_J:    w_pc_nxt = {w_pc4[31:28], r_instr[25:0], 2'b00};
                        OP_BEQ:  w_pc_nxt = bus.cmp_equal ? w_br_target : w_pc4;
                        OP_BNE:  w_pc_nxt = bus.cmp_equal ? w_pc4 : w_br_target;
                        OP_HALT: begin
                            w_pc_nxt     = r_pc;
                            w_halted_nxt = 1'b1;
                            w_state_nxt  = StHalt;
                        end
                        default: w_pc_nxt = w_pc4;
                    endcase
                end
            end
            StHalt: begin
                w_halted_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign bus.instrword = r_instr;
    assign bus.newinstr  = r_newinstr;
    assign bus.pc        = r_pc;
    assign bus.halted    = r_halted;
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: a driver issues programs and pushes expected
// {pc, instrword} per fetch; a monitor pops and compares on every newinstr pulse.
module tb_mips_fetch_unit;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CPI   = 5;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    mips_fetch_unit_if #(.IMEM_DEPTH(DEPTH)) bus ();

    mips_fetch_unit #(
        .IMEM_DEPTH(DEPTH),
        .CYCLES_PER_INSTR(CPI),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_imem [DEPTH];
    logic [31:0] m_pc;
    logic [63:0] exp_q [$];
    int          force_eq   = -1;
    bit          junk_loads = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int idx(input logic [31:0] p);
        return int'((p >> 2) % DEPTH);
    endfunction

    // Reference next-PC rule, written straight from the instruction semantics.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input bit eq);
        logic [31:0] p4;
        logic [31:0] tgt;
        logic [15:0] imm16;
        int          imm;
        int          op;
        p4    = p + 32'd4;
        imm16 = w[15:0];
        imm   = int'($signed(imm16));
        tgt   = p4 + 32'(imm * 4);
        op    = int'(w >> 26);
        case (op)
            2:       return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
            4:       return eq ? tgt : p4;
            5:       return eq ? p4 : tgt;
            63:      return p;
            default: return p4;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  op;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 4);
        case (sel)
            0:       op = 6'h00;
            1:       op = 6'h23;
            2:       op = 6'h02;
            3:       op = 6'h04;
            default: op = 6'h05;
        endcase
        return {op, r[25:0]};
    endfunction

    task automatic load(input int a, input logic [31:0] d, input bit accepted);
        bus.load_en   = 1'b1;
        bus.load_addr = AW'(a);
        bus.load_data = d;
        @(negedge clk);
        bus.load_en = 1'b0;
        if (accepted) m_imem[a] = d;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.newinstr === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called just after a negedge; asserts rst between edges and checks outputs at once.
    task automatic async_reset_check();
        #1;
        rst         = 1'b1;
        bus.run     = 1'b0;
        bus.load_en = 1'b0;
        #1;
        check("rst pc", bus.pc, RPC);
        check("rst instrword", bus.instrword, 32'h0);
        check("rst newinstr", 32'(bus.newinstr), 32'h0);
        check("rst halted", 32'(bus.halted), 32'h0);
        exp_q.delete();
        m_pc = RPC;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs n instructions from IDLE, dropping run during the last one's second EXEC cycle.
    task automatic exec_program(input int n, input int abort_i);
        bit          ok;
        bit          eq;
        int          t_prev;
        logic [31:0] word;
        exp_q.push_back({m_pc, m_imem[idx(m_pc)]});
        bus.run = 1'b1;
        t_prev  = cyc;
        word    = 32'h0;
        eq      = 1'b0;
        for (int i = 0; i < n; i++) begin
            wait_pulse(ok);
            if (!ok) begin
                n_checks++;
                $display("FAIL newinstr timeout: no pulse within 20 cycles, pc=%h", bus.pc);
                bus.run = 1'b0;
                return;
            end
            check("newinstr spacing", 32'(cyc - t_prev), (i == 0) ? 32'd2 : 32'(CPI + 1));
            t_prev = cyc;
            word   = m_imem[idx(m_pc)];
            for (int k = 0; k < CPI; k++) begin
                eq = 1'($urandom_range(0, 1));
                if (k == CPI - 1 && force_eq >= 0) eq = (force_eq != 0);
                bus.cmp_equal = eq;
                if (junk_loads && k == 0) begin
                    bus.load_en   = 1'b1;
                    bus.load_addr = AW'($urandom);
                    bus.load_data = $urandom;
                end
                if (junk_loads && k == 1) bus.load_en = 1'b0;
                if (i == n - 1 && k == 1) bus.run = 1'b0;
                if (i == abort_i && k == 2) begin
                    async_reset_check();
                    return;
                end
                if (k != CPI - 1) @(negedge clk);
            end
            if (word[31:26] == 6'h3F) return;
            m_pc = model_next(m_pc, word, eq);
            if (i < n - 1) exp_q.push_back({m_pc, m_imem[idx(m_pc)]});
        end
        repeat (3) @(negedge clk);
        check("idle pc", bus.pc, m_pc);
        check("idle instrword held", bus.instrword, word);
        check("idle newinstr", 32'(bus.newinstr), 32'h0);
    endtask

    // Monitor: every newinstr pulse must match the next expected fetch.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.newinstr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected newinstr: got pulse at pc=%h expected none",
                             bus.pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pc at newinstr", bus.pc, e[63:32]);
                    check("instrword at newinstr", bus.instrword, e[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = 32'h0;
        bus.cmp_equal = 1'b0;
        m_pc          = RPC;
        @(negedge clk);
        check("reset pc", bus.pc, RPC);
        check("reset instrword", bus.instrword, 32'h0);
        check("reset newinstr", 32'(bus.newinstr), 32'h0);
        check("reset halted", 32'(bus.halted), 32'h0);
        rst = 1'b0;

        // Sequential words, then beq taken.
        load(0, 32'h0022_1820, 1'b1);
        load(1, 32'h8C04_0004, 1'b1);
        load(2, 32'h1022_0003, 1'b1);
        force_eq = 1;
        exec_program(3, -1);
        check("beq taken pc", bus.pc, 32'h0000_0018);
        load(2, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        check("instrword unchanged by load", bus.instrword, 32'h1022_0003);
        load(2, 32'h1022_0003, 1'b1);

        // beq not taken.
        async_reset_check();
        force_eq = 0;
        exec_program(3, -1);
        check("beq not taken pc", bus.pc, 32'h0000_000C);

        // j to 0x40 wraps to word 0.
        async_reset_check();
        load(0, 32'h0800_0010, 1'b1);
        force_eq = -1;
        exec_program(2, -1);
        check("j pc", bus.pc, 32'h0000_0040);

        // bne with imm=-1 self-loops.
        async_reset_check();
        load(0, 32'h1400_FFFF, 1'b1);
        force_eq = 0;
        exec_program(3, -1);
        check("bne self-loop pc", bus.pc, 32'h0000_0000);

        // HALT retires and parks; loads are accepted while halted.
        async_reset_check();
        load(0, 32'h0022_1820, 1'b1);
        load(1, 32'hFC00_0000, 1'b1);
        force_eq = -1;
        exec_program(3, -1);
        repeat (15) @(negedge clk);
        check("halted", 32'(bus.halted), 32'h1);
        check("halt pc", bus.pc, 32'h0000_0004);
        check("halt instrword", bus.instrword, 32'hFC00_0000);
        load(7, 32'h2408_0007, 1'b1);
        bus.run = 1'b0;

        // Async reset mid-EXEC, then imem must survive a re-run.
        async_reset_check();
        load(0, 32'h0800_0007, 1'b1);
        exec_program(3, 1);
        exec_program(2, -1);

        // Randomized programs with ignored loads during EXEC.
        async_reset_check();
        for (int a = 0; a < int'(DEPTH); a++) load(a, rand_instr(), 1'b1);
        junk_loads = 1'b1;
        exec_program(25, -1);
        junk_loads = 1'b0;
        for (int j = 0; j < 4; j++) load(int'($urandom_range(0, DEPTH - 1)), rand_instr(), 1'b1);
        exec_program(20, -1);
        for (int j = 0; j < 3; j++) begin
            load(int'($urandom_range(0, DEPTH - 1)), rand_instr(), 1'b1);
            exec_program(int'($urandom_range(2, 8)), -1);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
